// File: rtl/bfu_r2_stream.sv
// Radix-2 FFT butterfly (DIT/DIF per item) with valid/ready streaming.
// Four register stages: capture, pre-add, complex multiply, post-add/scale/saturate.
module bfu_r2_stream #(
  parameter int DATA_W  = 16,
  parameter int TW_W    = 16,
  parameter int TW_FRAC = 14,
  parameter int TAG_W   = 8,
  parameter int ROUND   = 1,
  parameter int SAT     = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a_r,
  input  logic signed [DATA_W-1:0] in_a_i,
  input  logic signed [DATA_W-1:0] in_b_r,
  input  logic signed [DATA_W-1:0] in_b_i,
  input  logic signed [TW_W-1:0]   in_w_r,
  input  logic signed [TW_W-1:0]   in_w_i,
  input  logic                     in_mode,
  input  logic                     in_scale,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_a_r,
  output logic signed [DATA_W-1:0] out_a_i,
  output logic signed [DATA_W-1:0] out_b_r,
  output logic signed [DATA_W-1:0] out_b_i,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_ovf,
  output logic                     ovf_sticky,
  input  logic                     clr_ovf
);
  localparam int STAGES = 4;
  localparam int XW = DATA_W + 1;
  localparam int PW = DATA_W + TW_W + 2;
  localparam int SW = PW - TW_FRAC + 1;
  localparam logic signed [PW-1:0] RND_P = (ROUND != 0) ? (PW'(1) << (TW_FRAC - 1)) : PW'(0);
  localparam logic signed [SW-1:0] RND_S = (ROUND != 0) ? SW'(1) : SW'(0);
  localparam logic signed [SW-1:0] MAXV  = {{(SW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV  = ~MAXV;

  typedef struct packed {
    logic signed [DATA_W-1:0] a_r, a_i, b_r, b_i;
    logic signed [TW_W-1:0]   w_r, w_i;
    logic                     mode, scale;
    logic [TAG_W-1:0]         tag;
  } s1_t;

  typedef struct packed {
    logic signed [XW-1:0]   a_r, a_i, x_r, x_i;
    logic signed [TW_W-1:0] w_r, w_i;
    logic                   mode, scale;
    logic [TAG_W-1:0]       tag;
  } s2_t;

  typedef struct packed {
    logic signed [XW-1:0] a_r, a_i;
    logic signed [PW-1:0] p_r, p_i;
    logic                 mode, scale;
    logic [TAG_W-1:0]     tag;
  } s3_t;

  function automatic logic signed [XW-1:0] sx(input logic signed [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  // Optional halving, then range check; returns {ovf, clamped-or-wrapped value}.
  function automatic logic [DATA_W:0] post(input logic signed [SW-1:0] v, input logic sc);
    logic signed [SW-1:0] s;
    logic                 ov;
    logic [DATA_W-1:0]    o;
    s  = sc ? ((v + RND_S) >>> 1) : v;
    ov = (s > MAXV) || (s < MINV);
    o  = s[DATA_W-1:0];
    if (ov && SAT != 0) o = s[SW-1] ? MINV[DATA_W-1:0] : MAXV[DATA_W-1:0];
    return {ov, o};
  endfunction

  logic [STAGES:1] vld_pipe;
  logic            advance;
  s1_t             s1;
  s2_t             s2, s2_n;
  s3_t             s3, s3_n;
  logic signed [SW-1:0] t_r, t_i, a_r4, a_i4, ra_r, ra_i, rb_r, rb_i;
  logic [DATA_W:0]      q_ar, q_ai, q_br, q_bi;

  assign advance   = !vld_pipe[STAGES] || out_ready;
  assign in_ready  = advance;
  assign out_valid = vld_pipe[STAGES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       vld_pipe <= '0;
    else if (advance) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else if (advance) begin
      s1 <= '{a_r: in_a_r, a_i: in_a_i, b_r: in_b_r, b_i: in_b_i, w_r: in_w_r, w_i: in_w_i,
              mode: in_mode, scale: in_scale, tag: in_tag};
      s2 <= s2_n;
      s3 <= s3_n;
    end
  end

  // DIF forms A+B / A-B before the multiply; DIT multiplies B directly.
  always_comb begin
    s2_n.w_r   = s1.w_r;
    s2_n.w_i   = s1.w_i;
    s2_n.mode  = s1.mode;
    s2_n.scale = s1.scale;
    s2_n.tag   = s1.tag;
    if (s1.mode) begin
      s2_n.a_r = sx(s1.a_r) + sx(s1.b_r);
      s2_n.a_i = sx(s1.a_i) + sx(s1.b_i);
      s2_n.x_r = sx(s1.a_r) - sx(s1.b_r);
      s2_n.x_i = sx(s1.a_i) - sx(s1.b_i);
    end else begin
      s2_n.a_r = sx(s1.a_r);
      s2_n.a_i = sx(s1.a_i);
      s2_n.x_r = sx(s1.b_r);
      s2_n.x_i = sx(s1.b_i);
    end
  end

  always_comb begin
    s3_n.a_r   = s2.a_r;
    s3_n.a_i   = s2.a_i;
    s3_n.mode  = s2.mode;
    s3_n.scale = s2.scale;
    s3_n.tag   = s2.tag;
    s3_n.p_r   = PW'(s2.x_r) * PW'(s2.w_r) - PW'(s2.x_i) * PW'(s2.w_i);
    s3_n.p_i   = PW'(s2.x_r) * PW'(s2.w_i) + PW'(s2.x_i) * PW'(s2.w_r);
  end

  always_comb begin
    t_r  = SW'((s3.p_r + RND_P) >>> TW_FRAC);
    t_i  = SW'((s3.p_i + RND_P) >>> TW_FRAC);
    a_r4 = SW'(s3.a_r);
    a_i4 = SW'(s3.a_i);
    if (s3.mode) begin
      ra_r = a_r4;
      ra_i = a_i4;
      rb_r = t_r;
      rb_i = t_i;
    end else begin
      ra_r = a_r4 + t_r;
      ra_i = a_i4 + t_i;
      rb_r = a_r4 - t_r;
      rb_i = a_i4 - t_i;
    end
    q_ar = post(ra_r, s3.scale);
    q_ai = post(ra_i, s3.scale);
    q_br = post(rb_r, s3.scale);
    q_bi = post(rb_i, s3.scale);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_r <= '0;
      out_a_i <= '0;
      out_b_r <= '0;
      out_b_i <= '0;
      out_tag <= '0;
      out_ovf <= 1'b0;
    end else if (advance) begin
      out_a_r <= q_ar[DATA_W-1:0];
      out_a_i <= q_ai[DATA_W-1:0];
      out_b_r <= q_br[DATA_W-1:0];
      out_b_i <= q_bi[DATA_W-1:0];
      out_tag <= s3.tag;
      out_ovf <= q_ar[DATA_W] | q_ai[DATA_W] | q_br[DATA_W] | q_bi[DATA_W];
    end
  end

  // Set has priority over clear so an overflow in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                ovf_sticky <= 1'b0;
    else if (out_valid && out_ready && out_ovf) ovf_sticky <= 1'b1;
    else if (clr_ovf)                          ovf_sticky <= 1'b0;
  end
endmodule

// File: tb/tb_bfu_r2_stream.sv
// Bench for bfu_r2_stream: directed vectors plus a randomized stalled stream,
// run against a ROUND=1/SAT=1 build and a ROUND=0/SAT=0 build side by side.
module tb_bfu_r2_stream;
  typedef struct {
    logic signed [15:0] ar, ai, br, bi, wr, wi;
    logic               mode, scale;
    logic [7:0]         tag;
  } item_t;

  typedef struct {
    logic signed [15:0] ar, ai, br, bi;
    logic               ovf;
    logic [7:0]         tag;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               in_valid = 1'b0, in_mode = 1'b0, in_scale = 1'b0, out_ready = 1'b1, clr_ovf = 1'b0;
  logic signed [15:0] in_a_r = '0, in_a_i = '0, in_b_r = '0, in_b_i = '0, in_w_r = '0, in_w_i = '0;
  logic [7:0]         in_tag = '0;
  logic               in_ready, out_valid, out_ovf, ovf_sticky;
  logic signed [15:0] out_a_r, out_a_i, out_b_r, out_b_i;
  logic [7:0]         out_tag;
  logic               rt_in_ready, rt_out_valid, rt_out_ovf, rt_ovf_sticky;
  logic signed [15:0] rt_out_a_r, rt_out_a_i, rt_out_b_r, rt_out_b_i;
  logic [7:0]         rt_out_tag;

  int checks = 0;
  int passes = 0;

  bfu_r2_stream #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .TAG_W(8), .ROUND(1), .SAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a_r(in_a_r), .in_a_i(in_a_i), .in_b_r(in_b_r), .in_b_i(in_b_i),
    .in_w_r(in_w_r), .in_w_i(in_w_i), .in_mode(in_mode), .in_scale(in_scale), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a_r(out_a_r), .out_a_i(out_a_i), .out_b_r(out_b_r), .out_b_i(out_b_i),
    .out_tag(out_tag), .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf));

  bfu_r2_stream #(.DATA_W(16), .TW_W(16), .TW_FRAC(14), .TAG_W(8), .ROUND(0), .SAT(0)) u_rt (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rt_in_ready),
    .in_a_r(in_a_r), .in_a_i(in_a_i), .in_b_r(in_b_r), .in_b_i(in_b_i),
    .in_w_r(in_w_r), .in_w_i(in_w_i), .in_mode(in_mode), .in_scale(in_scale), .in_tag(in_tag),
    .out_valid(rt_out_valid), .out_ready(out_ready),
    .out_a_r(rt_out_a_r), .out_a_i(rt_out_a_i), .out_b_r(rt_out_b_r), .out_b_i(rt_out_b_i),
    .out_tag(rt_out_tag), .out_ovf(rt_out_ovf), .ovf_sticky(rt_ovf_sticky), .clr_ovf(clr_ovf));

  // ---------------- reference model (integer arithmetic) ----------------
  function automatic longint rsh(longint x, int sh, bit rnd);
    longint d, y, m;
    d = longint'(1) << sh;
    y = rnd ? x + d / 2 : x;
    m = y % d;
    if (m < 0) m += d;
    return (y - m) / d;
  endfunction

  function automatic logic [16:0] fit(longint v, bit sat);
    longint r, m;
    bit     ov;
    ov = (v > 32767) || (v < -32768);
    r  = v;
    if (ov && sat) r = (v > 0) ? 32767 : -32768;
    else if (ov) begin
      m = (v + 32768) % 65536;
      if (m < 0) m += 65536;
      r = m - 32768;
    end
    return {ov, r[15:0]};
  endfunction

  function automatic res_t model(item_t it, bit rnd, bit sat);
    longint ar, ai, br, bi, wr, wi, dr, di;
    longint v[4];
    logic [16:0] f[4];
    res_t r;
    ar = it.ar; ai = it.ai; br = it.br; bi = it.bi; wr = it.wr; wi = it.wi;
    if (!it.mode) begin
      dr = rsh(br * wr - bi * wi, 14, rnd);
      di = rsh(br * wi + bi * wr, 14, rnd);
      v[0] = ar + dr; v[1] = ai + di; v[2] = ar - dr; v[3] = ai - di;
    end else begin
      dr = ar - br;
      di = ai - bi;
      v[0] = ar + br; v[1] = ai + bi;
      v[2] = rsh(dr * wr - di * wi, 14, rnd);
      v[3] = rsh(dr * wi + di * wr, 14, rnd);
    end
    for (int k = 0; k < 4; k++) begin
      if (it.scale) v[k] = rsh(v[k], 1, rnd);
      f[k] = fit(v[k], sat);
    end
    r.ar = f[0][15:0]; r.ai = f[1][15:0]; r.br = f[2][15:0]; r.bi = f[3][15:0];
    r.ovf = f[0][16] | f[1][16] | f[2][16] | f[3][16];
    r.tag = it.tag;
    return r;
  endfunction

  // ---------------- helpers (no comparisons) ----------------
  function automatic item_t mk(int ar, int ai, int br, int bi, int wr, int wi, bit mode, bit scale, int tag);
    item_t it;
    it.ar = 16'(ar); it.ai = 16'(ai); it.br = 16'(br); it.bi = 16'(bi);
    it.wr = 16'(wr); it.wi = 16'(wi); it.mode = mode; it.scale = scale; it.tag = 8'(tag);
    return it;
  endfunction

  function automatic res_t mkr(int ar, int ai, int br, int bi, bit ovf, int tag);
    res_t r;
    r.ar = 16'(ar); r.ai = 16'(ai); r.br = 16'(br); r.bi = 16'(bi); r.ovf = ovf; r.tag = 8'(tag);
    return r;
  endfunction

  function automatic logic [72:0] pk(res_t r);
    return {r.ar, r.ai, r.br, r.bi, r.ovf, r.tag};
  endfunction

  function automatic res_t grab0();
    res_t r;
    r.ar = out_a_r; r.ai = out_a_i; r.br = out_b_r; r.bi = out_b_i; r.ovf = out_ovf; r.tag = out_tag;
    return r;
  endfunction

  function automatic res_t grab1();
    res_t r;
    r.ar = rt_out_a_r; r.ai = rt_out_a_i; r.br = rt_out_b_r; r.bi = rt_out_b_i; r.ovf = rt_out_ovf; r.tag = rt_out_tag;
    return r;
  endfunction

  task automatic set_in(item_t it);
    in_a_r = it.ar; in_a_i = it.ai; in_b_r = it.br; in_b_i = it.bi;
    in_w_r = it.wr; in_w_i = it.wi; in_mode = it.mode; in_scale = it.scale; in_tag = it.tag;
  endtask

  // One item through an idle pipeline; lat counts negedges from drive until out_valid.
  task automatic run_one(input item_t it, output int lat, output res_t r0, output res_t r1);
    @(negedge clk);
    set_in(it);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    r0 = grab0();
    r1 = grab1();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, rt_out_valid, ovf_sticky, rt_ovf_sticky} !== 4'b0)
      $display("FAIL reset_flags: got %b expected 0000", {out_valid, rt_out_valid, ovf_sticky, rt_ovf_sticky});
    else passes++;
    checks++;
    if (pk(grab0()) !== 73'd0 || pk(grab1()) !== 73'd0)
      $display("FAIL reset_data: got %h / %h expected 0", pk(grab0()), pk(grab1()));
    else passes++;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_dit();
    int lat; res_t r0, r1, e;
    run_one(mk(1000, -500, 200, 300, 16384, 0, 0, 0, 8'h11), lat, r0, r1);
    checks++;
    if (lat !== 4) $display("FAIL dit_latency: got %0d expected 4", lat); else passes++;
    e = mkr(1200, -200, 800, -800, 0, 8'h11);
    checks++;
    if (pk(r0) !== pk(e) || pk(r1) !== pk(e)) $display("FAIL dit_w_one: got %h / %h expected %h", pk(r0), pk(r1), pk(e));
    else passes++;
    run_one(mk(1000, -500, 200, 300, 0, 16384, 0, 0, 8'h12), lat, r0, r1);
    e = mkr(700, -300, 1300, -700, 0, 8'h12);
    checks++;
    if (pk(r0) !== pk(e) || pk(r1) !== pk(e)) $display("FAIL dit_w_j: got %h / %h expected %h", pk(r0), pk(r1), pk(e));
    else passes++;
  endtask

  task automatic test_dif();
    int lat; res_t r0, r1, e;
    run_one(mk(100, 50, 40, 10, 0, -16384, 1, 0, 8'h21), lat, r0, r1);
    e = mkr(140, 60, 40, -60, 0, 8'h21);
    checks++;
    if (pk(r0) !== pk(e) || pk(r1) !== pk(e)) $display("FAIL dif_w_mj: got %h / %h expected %h", pk(r0), pk(r1), pk(e));
    else passes++;
    checks++;
    if (lat !== 4) $display("FAIL dif_latency: got %0d expected 4", lat); else passes++;
  endtask

  task automatic test_round();
    int lat; res_t r0, r1, e0, e1;
    run_one(mk(0, 0, 3, 0, 8192, 0, 0, 0, 8'h31), lat, r0, r1);
    e0 = mkr(2, 0, -2, 0, 0, 8'h31);
    e1 = mkr(1, 0, -1, 0, 0, 8'h31);
    checks++;
    if (pk(r0) !== pk(e0)) $display("FAIL round_half_up: got %h expected %h", pk(r0), pk(e0)); else passes++;
    checks++;
    if (pk(r1) !== pk(e1)) $display("FAIL round_truncate: got %h expected %h", pk(r1), pk(e1)); else passes++;
  endtask

  task automatic test_overflow();
    int lat; res_t r0, r1, e0, e1;
    checks++;
    if (ovf_sticky !== 1'b0 || rt_ovf_sticky !== 1'b0) $display("FAIL sticky_idle: got %b%b expected 00", ovf_sticky, rt_ovf_sticky);
    else passes++;
    run_one(mk(30000, 0, 10000, 0, 16384, 0, 0, 0, 8'h41), lat, r0, r1);
    e0 = mkr(32767, 0, 20000, 0, 1, 8'h41);
    e1 = mkr(-25536, 0, 20000, 0, 1, 8'h41);
    checks++;
    if (pk(r0) !== pk(e0)) $display("FAIL ovf_saturate: got %h expected %h", pk(r0), pk(e0)); else passes++;
    checks++;
    if (pk(r1) !== pk(e1)) $display("FAIL ovf_wrap: got %h expected %h", pk(r1), pk(e1)); else passes++;
    run_one(mk(30000, 0, 10000, 0, 16384, 0, 0, 1, 8'h42), lat, r0, r1);
    e0 = mkr(20000, 0, 10000, 0, 0, 8'h42);
    checks++;
    if (pk(r0) !== pk(e0) || pk(r1) !== pk(e0)) $display("FAIL ovf_scaled: got %h / %h expected %h", pk(r0), pk(r1), pk(e0));
    else passes++;
    checks++;
    if (ovf_sticky !== 1'b1 || rt_ovf_sticky !== 1'b1) $display("FAIL sticky_set: got %b%b expected 11", ovf_sticky, rt_ovf_sticky);
    else passes++;
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    checks++;
    if (ovf_sticky !== 1'b0 || rt_ovf_sticky !== 1'b0) $display("FAIL sticky_clear: got %b%b expected 00", ovf_sticky, rt_ovf_sticky);
    else passes++;
  endtask

  task automatic test_stream();
    item_t items[20];
    res_t  q0[$], q1[$];
    res_t  a0, a1, p0, p1, e0, e1;
    int    sent = 0, cyc = 0, low = 0;
    bit    stalled = 0, did_rst = 0, st0 = 0, st1 = 0;
    for (int i = 0; i < 20; i++)
      items[i] = mk(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768,
                    int'($urandom_range(0, 32768)) - 16384, int'($urandom_range(0, 32768)) - 16384,
                    bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'h80 + i);
    while ((sent < 20 || q0.size() != 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (!did_rst && sent >= 8 && out_valid) begin
        did_rst  = 1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || rt_out_valid !== 1'b0 || pk(grab0()) !== 73'd0 || ovf_sticky !== 1'b0)
          $display("FAIL stream_async_reset: got valid=%b data=%h sticky=%b expected 0", out_valid, pk(grab0()), ovf_sticky);
        else passes++;
        q0.delete(); q1.delete();
        st0 = 0; st1 = 0; stalled = 0;
        @(negedge clk);
        rst_n = 1'b1;
        continue;
      end
      if (low > 0) begin out_ready = 1'b0; low--; end
      else if ($urandom_range(0, 5) == 0) begin out_ready = 1'b0; low = 2; end
      else out_ready = ($urandom_range(0, 3) != 0);
      in_valid = (sent < 20) && ($urandom_range(0, 3) != 0);
      if (sent < 20) set_in(items[sent]);
      #1;
      a0 = grab0();
      a1 = grab1();
      checks++;
      if (in_ready !== (!out_valid || out_ready) || rt_in_ready !== in_ready || rt_out_valid !== out_valid)
        $display("FAIL stream_in_ready: got %b (rt %b/%b) expected %b", in_ready, rt_in_ready, rt_out_valid, !out_valid || out_ready);
      else passes++;
      if (stalled) begin
        checks++;
        if (pk(a0) !== pk(p0) || pk(a1) !== pk(p1))
          $display("FAIL stream_stall_hold: got %h / %h expected %h / %h", pk(a0), pk(a1), pk(p0), pk(p1));
        else passes++;
      end
      checks++;
      if (ovf_sticky !== st0 || rt_ovf_sticky !== st1)
        $display("FAIL stream_sticky: got %b%b expected %b%b", ovf_sticky, rt_ovf_sticky, st0, st1);
      else passes++;
      if (out_valid && out_ready) begin
        checks++;
        if (q0.size() == 0) $display("FAIL stream_extra_result: got tag %h expected none", out_tag);
        else begin
          e0 = q0.pop_front();
          e1 = q1.pop_front();
          if (pk(a0) !== pk(e0) || pk(a1) !== pk(e1))
            $display("FAIL stream_result: got %h / %h expected %h / %h", pk(a0), pk(a1), pk(e0), pk(e1));
          else passes++;
          st0 = st0 | e0.ovf;
          st1 = st1 | e1.ovf;
        end
      end
      if (in_valid && in_ready) begin
        q0.push_back(model(items[sent], 1, 1));
        q1.push_back(model(items[sent], 0, 0));
        sent++;
      end
      stalled = out_valid && !out_ready;
      p0 = a0;
      p1 = a1;
    end
    in_valid = 1'b0;
    checks++;
    if (sent != 20 || q0.size() != 0 || !did_rst)
      $display("FAIL stream_drain: got sent=%0d pending=%0d reset=%0d expected 20/0/1", sent, q0.size(), did_rst);
    else passes++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dit();
    test_dif();
    test_round();
    test_overflow();
    test_stream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
